// File: rtl/mure_pkg.sv
// Shared widths, FSM state type and the latched bundle layout for the
// multi-retirement serializer.
package mure_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_LEN   = 32;
  localparam int unsigned CAUSE_LEN  = 5;
  localparam int unsigned PRIV_LEN   = 2;
  // Slot count the bundle struct is laid out for; the serializer's
  // NrRetiredInstr parameter must match it.
  localparam int unsigned NR_RETIRED = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    TRAP = 2'd2
  } mure_ser_state_e;

  // One accepted bundle: remaining-slot mask, packed slot payloads and the
  // trap information shared by every slot.
  typedef struct packed {
    logic [NR_RETIRED-1:0]          mask;
    logic [NR_RETIRED*INST_LEN-1:0] insts;
    logic [NR_RETIRED*XLEN-1:0]     pcs;
    logic                           exc;
    logic                           irq;
    logic                           eret;
    logic [CAUSE_LEN-1:0]           cause;
    logic [XLEN-1:0]                tval;
    logic [XLEN-1:0]                epc;
    logic [PRIV_LEN-1:0]            priv;
  } mure_bundle_s;

endpackage

// File: rtl/mure_lzc_onehot.sv
// Lowest-set-bit finder: index, one-hot isolation and an "exactly one bit
// set" flag used to spot the last remaining slot of a bundle.
module mure_lzc_onehot #(
  parameter int unsigned Width = 2,
  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] bits,
  output logic [IdxW-1:0]  idx,
  output logic [Width-1:0] onehot,
  output logic             single
);

  assign onehot = bits & (~bits + Width'(1));
  assign single = (bits != '0) && ((bits & (bits - Width'(1))) == '0);

  // Scan from the top down so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (bits[i]) idx = IdxW'(i);
    end
  end

endmodule

// File: rtl/mure_retire_serializer.sv
// Turns a multi-slot retirement bundle into one-instruction-per-beat output
// for a single-retirement trace encoder, appending a trap beat when the
// bundle ends in an exception or interrupt.
module mure_retire_serializer
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = NR_RETIRED
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               bundle_valid_i,
  output logic                               bundle_ready_o,
  input  logic [NrRetiredInstr-1:0]          valids_i,
  input  logic [NrRetiredInstr*INST_LEN-1:0] insts_i,
  input  logic [NrRetiredInstr*XLEN-1:0]     pcs_i,
  input  logic                               exception_i,
  input  logic                               interrupt_i,
  input  logic                               eret_i,
  input  logic [CAUSE_LEN-1:0]               cause_i,
  input  logic [XLEN-1:0]                    tval_i,
  input  logic [XLEN-1:0]                    epc_i,
  input  logic [PRIV_LEN-1:0]                priv_lvl_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               iretired_o,
  output logic                               exception_o,
  output logic                               interrupt_o,
  output logic                               eret_o,
  output logic [INST_LEN-1:0]                inst_data_o,
  output logic [XLEN-1:0]                    pc_o,
  output logic [XLEN-1:0]                    epc_o,
  output logic [CAUSE_LEN-1:0]               cause_o,
  output logic [XLEN-1:0]                    tval_o,
  output logic [PRIV_LEN-1:0]                priv_lvl_o
);

  localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  mure_ser_state_e             state, state_next, accept_state;
  mure_bundle_s                bundle;
  logic [IdxW-1:0]             slot;
  logic [NrRetiredInstr-1:0]   slot_onehot;
  logic                        last_slot;
  logic                        trap_pending;
  logic                        final_beat;
  logic                        handshake;

  mure_lzc_onehot #(
    .Width (NrRetiredInstr)
  ) u_lzc (
    .bits   (bundle.mask),
    .idx    (slot),
    .onehot (slot_onehot),
    .single (last_slot)
  );

  assign trap_pending = bundle.exc | bundle.irq;
  // The beat that finishes the bundle: last slot with no trap to follow, or
  // the trap beat itself. Completing it lets the next bundle in without a gap.
  assign final_beat     = ((state == EMIT) && last_slot && !trap_pending) || (state == TRAP);
  assign bundle_ready_o = (state == IDLE) || (final_beat && out_ready_i);
  assign handshake      = bundle_valid_i && bundle_ready_o;

  assign epc_o      = bundle.epc;
  assign cause_o    = bundle.cause;
  assign tval_o     = bundle.tval;
  assign priv_lvl_o = bundle.priv;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Bundle register: load on handshake, otherwise retire the current slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bundle <= '0;
    end else if (handshake) begin
      bundle.mask  <= valids_i;
      bundle.insts <= insts_i;
      bundle.pcs   <= pcs_i;
      bundle.exc   <= exception_i;
      bundle.irq   <= interrupt_i;
      bundle.eret  <= eret_i;
      bundle.cause <= cause_i;
      bundle.tval  <= tval_i;
      bundle.epc   <= epc_i;
      bundle.priv  <= priv_lvl_i;
    end else if ((state == EMIT) && out_ready_i) begin
      bundle.mask <= bundle.mask & ~slot_onehot;
    end
  end

  // Next-state and beat payload.
  always_comb begin
    state_next   = state;
    accept_state = IDLE;
    out_valid_o  = 1'b0;
    iretired_o   = 1'b0;
    exception_o  = 1'b0;
    interrupt_o  = 1'b0;
    eret_o       = 1'b0;
    inst_data_o  = '0;
    pc_o         = '0;

    // Where an incoming bundle leads; an empty, trap-free bundle is dropped.
    if (valids_i != '0)                  accept_state = EMIT;
    else if (exception_i || interrupt_i) accept_state = TRAP;

    unique case (state)
      IDLE: begin
        if (handshake) state_next = accept_state;
      end
      EMIT: begin
        out_valid_o = 1'b1;
        iretired_o  = 1'b1;
        eret_o      = last_slot && bundle.eret;
        inst_data_o = bundle.insts[slot*INST_LEN +: INST_LEN];
        pc_o        = bundle.pcs[slot*XLEN +: XLEN];
        if (out_ready_i && last_slot) begin
          if (trap_pending)   state_next = TRAP;
          else if (handshake) state_next = accept_state;
          else                state_next = IDLE;
        end
      end
      TRAP: begin
        out_valid_o = 1'b1;
        interrupt_o = bundle.irq;
        exception_o = bundle.exc && !bundle.irq;
        pc_o        = bundle.epc;
        if (out_ready_i) state_next = handshake ? accept_state : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mure_retire_serializer.sv
// Directed bench for mure_retire_serializer with a queue-based scoreboard.
module tb_mure_retire_serializer;
  import mure_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   bundle_valid;
  logic                   bundle_ready;
  logic [1:0]             valids;
  logic [2*INST_LEN-1:0]  insts;
  logic [2*XLEN-1:0]      pcs;
  logic                   exception_in, interrupt_in, eret_in;
  logic [CAUSE_LEN-1:0]   cause_in;
  logic [XLEN-1:0]        tval_in, epc_in;
  logic [PRIV_LEN-1:0]    priv_in;
  logic                   out_valid, out_ready;
  logic                   iretired, exception_out, interrupt_out, eret_out;
  logic [INST_LEN-1:0]    inst_data;
  logic [XLEN-1:0]        pc, epc_out, tval_out;
  logic [CAUSE_LEN-1:0]   cause_out;
  logic [PRIV_LEN-1:0]    priv_out;

  always #5 clk = ~clk;

  mure_retire_serializer #(.NrRetiredInstr(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bundle_valid_i (bundle_valid),
    .bundle_ready_o (bundle_ready),
    .valids_i       (valids),
    .insts_i        (insts),
    .pcs_i          (pcs),
    .exception_i    (exception_in),
    .interrupt_i    (interrupt_in),
    .eret_i         (eret_in),
    .cause_i        (cause_in),
    .tval_i         (tval_in),
    .epc_i          (epc_in),
    .priv_lvl_i     (priv_in),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .iretired_o     (iretired),
    .exception_o    (exception_out),
    .interrupt_o    (interrupt_out),
    .eret_o         (eret_out),
    .inst_data_o    (inst_data),
    .pc_o           (pc),
    .epc_o          (epc_out),
    .cause_o        (cause_out),
    .tval_o         (tval_out),
    .priv_lvl_o     (priv_out)
  );

  typedef struct packed {
    logic                 iret;
    logic                 exc;
    logic                 irq;
    logic                 eret;
    logic [INST_LEN-1:0]  inst;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      epc;
    logic [CAUSE_LEN-1:0] cause;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_act, mon_exp;
  int    tests  = 0;
  int    failed = 0;

  task automatic expect_beat(input logic iret, input logic exc, input logic irq,
                             input logic eret, input logic [31:0] inst,
                             input logic [31:0] bpc, input logic [31:0] bepc,
                             input logic [4:0] bcause);
    beat_t b;
    b.iret = iret; b.exc = exc; b.irq = irq; b.eret = eret;
    b.inst = inst; b.pc = bpc; b.epc = bepc; b.cause = bcause;
    exp_q.push_back(b);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer a bundle and return 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [31:0] p0, input logic [31:0] p1, input logic exc,
                      input logic irq, input logic er, input logic [4:0] c,
                      input logic [31:0] tv, input logic [31:0] ep,
                      input logic [1:0] pr, input bit hold);
    int guard;
    valids = v; insts = {i1, i0}; pcs = {p1, p0};
    exception_in = exc; interrupt_in = irq; eret_in = er;
    cause_in = c; tval_in = tv; epc_in = ep; priv_in = pr;
    bundle_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bundle_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bundle_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: bundle_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    if (!hold) bundle_valid = 1'b0;
  endtask

  // Monitor: every accepted beat is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        mon_act.iret  = iretired;
        mon_act.exc   = exception_out;
        mon_act.irq   = interrupt_out;
        mon_act.eret  = eret_out;
        mon_act.inst  = inst_data;
        mon_act.pc    = pc;
        mon_act.epc   = epc_out;
        mon_act.cause = cause_out;
        tests++;
        if (exp_q.size() == 0) begin
          failed++;
          $display("FAIL unexpected_beat: got beat %0h, expected none", mon_act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_act !== mon_exp) begin
            failed++;
            $display("FAIL beat: got %0h, expected %0h", mon_act, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    int waited;
    bundle_valid = 1'b0; valids = '0; insts = '0; pcs = '0;
    exception_in = 1'b0; interrupt_in = 1'b0; eret_in = 1'b0;
    cause_in = '0; tval_in = '0; epc_in = '0; priv_in = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_bundle_ready", 64'(bundle_ready), 64'd1);
    check("reset_payload", {iretired, exception_out, interrupt_out, eret_out, pc, cause_out},
          64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two slots, no trap.
    expect_beat(1, 0, 0, 0, 32'h00100093, 32'h1000, 32'h0, 5'd0);
    expect_beat(1, 0, 0, 0, 32'h00200113, 32'h1004, 32'h0, 5'd0);
    send(2'b11, 32'h00100093, 32'h00200113, 32'h1000, 32'h1004, 0, 0, 0, 5'd0, 32'h0,
         32'h0, 2'd3, 0);
    @(negedge clk);
    check("t1_ready_beat1", 64'(bundle_ready), 64'd0);
    @(negedge clk);
    check("t1_ready_beat2", 64'(bundle_ready), 64'd1);
    @(posedge clk);
    #1;
    check("t1_idle", 64'(out_valid), 64'd0);

    // Slot 1 only, then an exception beat.
    expect_beat(1, 0, 0, 0, 32'h0000a023, 32'h2004, 32'h2008, 5'd2);
    expect_beat(0, 1, 0, 0, 32'h0, 32'h2008, 32'h2008, 5'd2);
    send(2'b10, 32'hdeadbeef, 32'h0000a023, 32'h2000, 32'h2004, 1, 0, 0, 5'd2, 32'h55,
         32'h2008, 2'd1, 0);
    @(posedge clk);
    #1;
    check("t2_trap_tval_priv", {tval_out, 30'd0, priv_out}, {32'h55, 30'd0, 2'd1});
    @(posedge clk);
    #1;
    check("t2_idle", 64'(out_valid), 64'd0);

    // Interrupt with no retiring slot.
    expect_beat(0, 0, 1, 0, 32'h0, 32'h3000, 32'h3000, 5'd7);
    send(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, 5'd7, 32'h0, 32'h3000, 2'd3, 0);
    @(posedge clk);
    #1;
    check("t3_idle", 64'(out_valid), 64'd0);

    // Empty, trap-free bundle is dropped.
    send(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd0, 0);
    @(negedge clk);
    check("t3_drop", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Exception and interrupt together report as interrupt.
    expect_beat(1, 0, 0, 0, 32'h00000013, 32'h3800, 32'h3900, 5'd9);
    expect_beat(0, 0, 1, 0, 32'h0, 32'h3900, 32'h3900, 5'd9);
    send(2'b01, 32'h00000013, 32'h0, 32'h3800, 32'h0, 1, 1, 0, 5'd9, 32'h0, 32'h3900,
         2'd3, 0);
    repeat (2) @(posedge clk);
    #1;

    // Stall on beat 1 for 3 cycles, xRET on slot 1.
    expect_beat(1, 0, 0, 0, 32'h00000513, 32'h4000, 32'h0, 5'd0);
    expect_beat(1, 0, 0, 1, 32'h30200073, 32'h4004, 32'h0, 5'd0);
    out_ready = 1'b0;
    send(2'b11, 32'h00000513, 32'h30200073, 32'h4000, 32'h4004, 0, 0, 1, 5'd0, 32'h0,
         32'h0, 2'd3, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_stall_hold", {out_valid, iretired, eret_out, pc, inst_data[28:0]},
            {1'b1, 1'b1, 1'b0, 32'h4000, 29'h00000513});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back bundles with valid held high.
    expect_beat(1, 0, 0, 0, 32'h1, 32'h5000, 32'h0, 5'd0);
    expect_beat(1, 0, 0, 0, 32'h2, 32'h5004, 32'h0, 5'd0);
    expect_beat(1, 0, 0, 0, 32'h3, 32'h6000, 32'h0, 5'd0);
    expect_beat(1, 0, 0, 0, 32'h4, 32'h6004, 32'h0, 5'd0);
    send(2'b11, 32'h1, 32'h2, 32'h5000, 32'h5004, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd3, 1);
    fork
      send(2'b11, 32'h3, 32'h4, 32'h6000, 32'h6004, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd3, 0);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("t5_no_bubble", 64'(out_valid), 64'd1);
        end
      end
    join
    @(posedge clk);
    #1;
    check("t5_idle", 64'(out_valid), 64'd0);

    // Reset during the first beat of a two-slot bundle.
    send(2'b11, 32'h7, 32'h8, 32'h7000, 32'h7004, 0, 0, 0, 5'd0, 32'h0, 32'h0, 2'd3, 0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_valid", 64'(out_valid), 64'd0);
    check("t6_reset_ready", 64'(bundle_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t6_no_stale", {62'd0, out_valid, bundle_ready}, 64'd1);
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
